// File: rtl/riscv_pkg.sv
// Shared CPU definitions: data width, register index width and the
// {rd, data} writeback entry carried from the execution units to the
// register file write port.
package riscv_pkg;
   localparam int XLEN       = 32;
   localparam int NREG       = 32;
   localparam int REG_ADDR_W = $clog2(NREG);

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of writeback entries.
//   clk, rst     : clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata  : enqueue an entry (ignored when full)
//   pop, rdata   : dequeue the head (ignored when empty); rdata shows the head
//   count        : number of stored entries
//   full, empty  : occupancy flags
module wb_fifo
   import riscv_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  wb_entry_t        wdata,
   input  logic             pop,
   output wb_entry_t        rdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             push_ok, pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Payload storage needs no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
         if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter + register scoreboard in front of the single register
// file write port.
//   iss_valid/iss_rd           : issued instruction marks its rd busy
//   alu_valid/alu_rd/alu_data  : ALU result, never back-pressured, always wins
//   ld_valid/ld_ready/ld_rd/ld_data : load result handshake into a FIFO
//   rf_reg_write/rf_write_reg/rf_write_data : registered write stream
//   query_rs1/2 -> busy_rs1/2  : combinational busy lookup for decode
module wb_arbiter
   import riscv_pkg::*;
#(
   parameter int LD_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  iss_valid,
   input  logic [REG_ADDR_W-1:0] iss_rd,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [REG_ADDR_W-1:0] ld_rd,
   input  logic [XLEN-1:0]       ld_data,
   output logic                  rf_reg_write,
   output logic [REG_ADDR_W-1:0] rf_write_reg,
   output logic [XLEN-1:0]       rf_write_data,
   input  logic [REG_ADDR_W-1:0] query_rs1,
   input  logic [REG_ADDR_W-1:0] query_rs2,
   output logic                  busy_rs1,
   output logic                  busy_rs2
);
   localparam int LD_CNT_W = $clog2(LD_DEPTH + 1);

   wb_entry_t           ld_in, ld_head, sel;
   logic [LD_CNT_W-1:0] ld_count;
   logic                ld_full, ld_empty, ld_push, ld_pop, sel_vld;
   logic [NREG-1:0]     busy, busy_nxt;

   // No pass-through when full: a same-cycle pop does not open the slot.
   assign ld_ready = !rst && (ld_count < LD_CNT_W'(LD_DEPTH));
   assign ld_push  = ld_valid && ld_ready;
   assign ld_pop   = !alu_valid && !ld_empty;
   assign ld_in    = '{rd: ld_rd, data: ld_data};

   wb_fifo #(.DEPTH(LD_DEPTH)) u_ld_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ld_push),
      .wdata (ld_in),
      .pop   (ld_pop),
      .rdata (ld_head),
      .count (ld_count),
      .full  (ld_full),
      .empty (ld_empty)
   );

   always_comb begin
      sel_vld = alu_valid || !ld_empty;
      sel     = alu_valid ? '{rd: alu_rd, data: alu_data} : ld_head;
   end

   // x0 entries are still selected (so a load to x0 drains) but never write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_reg_write  <= 1'b0;
         rf_write_reg  <= '0;
         rf_write_data <= '0;
      end else begin
         rf_reg_write <= sel_vld && (sel.rd != '0);
         if (sel_vld) begin
            rf_write_reg  <= sel.rd;
            rf_write_data <= sel.data;
         end
      end
   end

   // Clear on the committing edge, then set, so a same-edge re-issue wins.
   always_comb begin
      busy_nxt = busy;
      if (rf_reg_write) busy_nxt[rf_write_reg] = 1'b0;
      if (iss_valid && iss_rd != '0) busy_nxt[iss_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

   assign busy_rs1 = busy[query_rs1];
   assign busy_rs2 = busy[query_rs2];

   a_full_blocks: assert property (@(posedge clk) disable iff (rst) ld_full |-> !ld_ready);
endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
   localparam int LD_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        iss_valid = 0, alu_valid = 0, ld_valid = 0;
   logic [4:0]  iss_rd = 0, alu_rd = 0, ld_rd = 0, query_rs1 = 0, query_rs2 = 0;
   logic [31:0] alu_data = 0, ld_data = 0;
   logic        ld_ready, rf_reg_write, busy_rs1, busy_rs2;
   logic [4:0]  rf_write_reg;
   logic [31:0] rf_write_data;

   wb_arbiter #(.LD_DEPTH(LD_DEPTH)) dut (
      .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rd(iss_rd),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .rf_reg_write(rf_reg_write), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
      .query_rs1(query_rs1), .query_rs2(query_rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, iss_v, alu_v, ld_v;
      logic [4:0]  iss_rd, alu_rd, ld_rd, q1, q2;
      logic [31:0] alu_d, ld_d;
   } stim_t;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   int  checks = 0, failures = 0;
   wr_t expq[$];       // expected rf_* contents after each edge
   wr_t ldq[$];        // model of buffered loads
   bit  bm[32];        // model busy bits
   wr_t cur;           // model of what sits on rf_* now

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive at negedge, check combinational outputs, then
   // advance the reference model to the state after the coming edge.
   task automatic step(input stim_t s);
      bit  rdy;
      wr_t e, t;
      @(negedge clk);
      rst = s.rst; iss_valid = s.iss_v; iss_rd = s.iss_rd;
      alu_valid = s.alu_v; alu_rd = s.alu_rd; alu_data = s.alu_d;
      ld_valid = s.ld_v; ld_rd = s.ld_rd; ld_data = s.ld_d;
      query_rs1 = s.q1; query_rs2 = s.q2;
      #1;
      rdy = !s.rst && (ldq.size() < LD_DEPTH);
      chk("ld_ready", ld_ready, rdy);
      chk("busy_rs1", busy_rs1, s.rst ? 1'b0 : bm[s.q1]);
      chk("busy_rs2", busy_rs2, s.rst ? 1'b0 : bm[s.q2]);
      if (s.rst) begin
         ldq.delete();
         foreach (bm[i]) bm[i] = 0;
         cur = '{0, 0, 0};
      end else begin
         e = '{0, 0, 0};
         if (s.alu_v) e = '{s.alu_rd != 0, s.alu_rd, s.alu_d};
         else if (ldq.size() > 0) begin
            t = ldq.pop_front();
            e = '{t.rd != 0, t.rd, t.data};
         end
         if (s.ld_v && rdy) ldq.push_back('{1'b1, s.ld_rd, s.ld_d});
         if (cur.we) bm[cur.rd] = 0;
         if (s.iss_v && s.iss_rd != 0) bm[s.iss_rd] = 1;
         cur = e;
         expq.push_back(e);
      end
   endtask

   // Monitor: compare registered write stream against the scoreboard.
   initial forever begin
      wr_t e;
      @(posedge clk); #1;
      if (rst) begin
         chk("rst_rf_we", rf_reg_write, 0);
         chk("rst_rf_reg", rf_write_reg, 0);
         chk("rst_rf_data", rf_write_data, 0);
      end else if (expq.size() > 0) begin
         e = expq.pop_front();
         chk("rf_we", rf_reg_write, e.we);
         if (e.we) begin
            chk("rf_reg", rf_write_reg, e.rd);
            chk("rf_data", rf_write_data, e.data);
         end
      end
   end

   function automatic stim_t idle(input logic [4:0] q1 = 0, input logic [4:0] q2 = 0);
      stim_t s = '{default: 0};
      s.q1 = q1; s.q2 = q2;
      return s;
   endfunction

   initial begin
      stim_t s;
      // reset state
      s = idle(); s.rst = 1;
      repeat (3) step(s);
      repeat (2) step(idle());

      // ALU path: busy for 5 across cycles 1..3, write in cycle 3
      s = idle(5); s.iss_v = 1; s.iss_rd = 5; step(s);
      step(idle(5));
      s = idle(5); s.alu_v = 1; s.alu_rd = 5; s.alu_d = 32'hDEADBEEF; step(s);
      repeat (3) step(idle(5));

      // collision: ALU first, load next cycle
      s = idle(3, 4); s.alu_v = 1; s.alu_rd = 3; s.alu_d = 32'h11;
      s.ld_v = 1; s.ld_rd = 4; s.ld_d = 32'h22; step(s);
      repeat (3) step(idle());

      // backpressure: ALU 4 cycles, loads 8,9,10 held on ld_valid
      for (int i = 0; i < 7; i++) begin
         s = idle(8, 10);
         s.alu_v = (i < 4); s.alu_rd = 5'(20 + i); s.alu_d = 32'(i);
         s.ld_v = 1; s.ld_rd = (i == 0) ? 5'd8 : (i == 1) ? 5'd9 : 5'd10;
         s.ld_d = 32'h100 + 32'(s.ld_rd);
         step(s);
      end
      repeat (4) step(idle());

      // x0 handling
      s = idle(0, 0); s.alu_v = 1; s.alu_rd = 0; s.alu_d = 1;
      s.ld_v = 1; s.ld_rd = 0; s.ld_d = 2; s.iss_v = 1; s.iss_rd = 0; step(s);
      repeat (3) step(idle(0, 0));

      // set/clear race on x12
      s = idle(12); s.iss_v = 1; s.iss_rd = 12; step(s);
      s = idle(12); s.alu_v = 1; s.alu_rd = 12; s.alu_d = 32'hC; step(s);
      s = idle(12); s.iss_v = 1; s.iss_rd = 12; step(s);
      repeat (2) step(idle(12));
      s = idle(12); s.alu_v = 1; s.alu_rd = 12; s.alu_d = 32'hD; step(s);
      repeat (2) step(idle(12));

      // mid-stream reset with two loads buffered and x7 busy
      s = idle(7); s.iss_v = 1; s.iss_rd = 7; s.alu_v = 1; s.alu_rd = 1;
      s.ld_v = 1; s.ld_rd = 14; s.ld_d = 32'hE; step(s);
      s = idle(7); s.alu_v = 1; s.alu_rd = 2; s.ld_v = 1; s.ld_rd = 15; s.ld_d = 32'hF; step(s);
      s = idle(7); s.alu_v = 1; s.alu_rd = 3; step(s);
      s = idle(7); s.rst = 1; repeat (2) step(s);
      repeat (4) step(idle(7, 14));

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         s.rst    = ($urandom_range(0, 99) < 2);
         s.iss_v  = $urandom_range(0, 1);
         s.iss_rd = 5'($urandom_range(0, 15));
         s.alu_v  = ($urandom_range(0, 99) < 45);
         s.alu_rd = 5'($urandom_range(0, 15));
         s.alu_d  = $urandom;
         s.ld_v   = $urandom_range(0, 1);
         s.ld_rd  = 5'($urandom_range(0, 15));
         s.ld_d   = $urandom;
         s.q1     = 5'($urandom_range(0, 15));
         s.q2     = 5'($urandom_range(0, 31));
         step(s);
      end
      repeat (6) step(idle());

      @(posedge clk); #2;
      chk("drain", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
